// File: rtl/entrada_condicionada.sv
// Push-button input conditioning: per-channel two-flop synchroniser, polarity
// normalisation, counter debounce, press/release pulses and optional auto-repeat.
module entrada_condicionada #(
    parameter int N_CH       = 4,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int DEB_CYCLES = 500000,
    parameter int REP_DELAY  = 25000000,
    parameter int REP_PERIOD = 5000000
) (
    input  logic            clk50,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    input  logic [N_CH-1:0] rep_en,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release
);

    localparam int HOLD_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int DEB_W    = $clog2(DEB_CYCLES);
    localparam int HOLD_W   = $clog2(HOLD_MAX);

    localparam logic [DEB_W-1:0]  DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REP_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REP_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        PERIOD = 2'd2
    } rep_state_t;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic              raw_norm;
        logic              s1_reg;
        logic              s2_reg;
        logic              level_reg;
        logic              level_next;
        logic              press_reg;
        logic              press_next;
        logic              rel_reg;
        logic              rel_next;
        logic [DEB_W-1:0]  deb_cnt_reg;
        logic [DEB_W-1:0]  deb_cnt_next;
        logic [HOLD_W-1:0] hold_cnt_reg;
        logic [HOLD_W-1:0] hold_cnt_next;
        rep_state_t        state_reg;
        rep_state_t        state_next;
        logic              rep_pulse;

        // After normalisation 1 always means pressed, whatever the board wiring.
        assign raw_norm = btn_in[gi] ^ ACTIVE_LOW;

        always_comb begin
            level_next   = level_reg;
            deb_cnt_next = deb_cnt_reg;
            if (s2_reg == level_reg) begin
                deb_cnt_next = '0;
            end else if (deb_cnt_reg == DEB_LAST) begin
                level_next   = s2_reg;
                deb_cnt_next = '0;
            end else begin
                deb_cnt_next = deb_cnt_reg + 1'b1;
            end
        end

        // The FSM looks at the level being registered this edge, so a release
        // landing on a terminal count silences the repeat in the same cycle.
        always_comb begin
            state_next    = state_reg;
            hold_cnt_next = hold_cnt_reg;
            rep_pulse     = 1'b0;
            if (!level_next || !rep_en[gi]) begin
                state_next    = IDLE;
                hold_cnt_next = '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_next    = DELAY;
                        hold_cnt_next = '0;
                    end
                    DELAY: begin
                        if (hold_cnt_reg == DELAY_LAST) begin
                            rep_pulse     = 1'b1;
                            hold_cnt_next = '0;
                            state_next    = PERIOD;
                        end else begin
                            hold_cnt_next = hold_cnt_reg + 1'b1;
                        end
                    end
                    PERIOD: begin
                        if (hold_cnt_reg == PERIOD_LAST) begin
                            rep_pulse     = 1'b1;
                            hold_cnt_next = '0;
                        end else begin
                            hold_cnt_next = hold_cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_next    = IDLE;
                        hold_cnt_next = '0;
                    end
                endcase
            end
        end

        // A rising level implies the FSM was idle, so rise and repeat never stack.
        assign press_next = (level_next & ~level_reg) | rep_pulse;
        assign rel_next   = ~level_next & level_reg;

        always_ff @(posedge clk50 or negedge rst_n) begin
            if (!rst_n) begin
                s1_reg       <= 1'b0;
                s2_reg       <= 1'b0;
                level_reg    <= 1'b0;
                press_reg    <= 1'b0;
                rel_reg      <= 1'b0;
                deb_cnt_reg  <= '0;
                hold_cnt_reg <= '0;
                state_reg    <= IDLE;
            end else begin
                s1_reg       <= raw_norm;
                s2_reg       <= s1_reg;
                level_reg    <= level_next;
                press_reg    <= press_next;
                rel_reg      <= rel_next;
                deb_cnt_reg  <= deb_cnt_next;
                hold_cnt_reg <= hold_cnt_next;
                state_reg    <= state_next;
            end
        end

        assign btn_level[gi]   = level_reg;
        assign btn_press[gi]   = press_reg;
        assign btn_release[gi] = rel_reg;
    end

endmodule

// File: tb/tb_entrada_condicionada.sv
// Self-checking bench for entrada_condicionada: expected press/release events are
// queued with their cycle number and matched against the pulses the DUT emits.
module tb_entrada_condicionada;

    localparam int N_CH = 4;

    logic            clk50 = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] rep_en;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] btn_press;
    logic [N_CH-1:0] btn_release;

    entrada_condicionada #(
        .N_CH      (N_CH),
        .ACTIVE_LOW(1'b1),
        .DEB_CYCLES(4),
        .REP_DELAY (10),
        .REP_PERIOD(3)
    ) dut (
        .clk50      (clk50),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .rep_en     (rep_en),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk50 = ~clk50;

    int cyc = 0;
    always @(posedge clk50) cyc <= cyc + 1;

    typedef struct {
        int t;
        int ch;
        bit is_press;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [1:0] mon_act;
    logic [1:0] mon_want;
    bit   mon_here;

    // Scoreboard: every pulse seen, and every pulse expected, is one comparison.
    always @(negedge clk50) begin
        while (exp_q.size() != 0 && exp_q[0].t < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_event ch%0d cyc %0d: observed no pulse, expected %s",
                     exp_q[0].ch, exp_q[0].t, exp_q[0].is_press ? "press" : "release");
            void'(exp_q.pop_front());
        end
        for (int c = 0; c < N_CH; c++) begin
            mon_act  = {btn_press[c], btn_release[c]};
            mon_here = (exp_q.size() != 0) && (exp_q[0].t == cyc) && (exp_q[0].ch == c);
            mon_want = 2'b00;
            if (mon_here) begin
                mon_want = exp_q[0].is_press ? 2'b10 : 2'b01;
                void'(exp_q.pop_front());
            end
            if (mon_here || mon_act != 2'b00) begin
                checks++;
                if (mon_act !== mon_want) begin
                    errors++;
                    $display("FAIL pulse_ch%0d cyc %0d: observed press,release=%b expected %b",
                             c, cyc, mon_act, mon_want);
                end
            end
        end
    end

    task automatic push_ev(input int t, input int ch, input bit p);
        ev_t e;
        e.t = t;
        e.ch = ch;
        e.is_press = p;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk50);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk50);
    endtask

    task automatic test_reset;
        int n;
        btn_in = 4'b0000;
        rep_en = 4'b0000;
        rst_n  = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk50);
        checks++;
        if (btn_level !== 4'b0000) begin
            errors++; $display("FAIL reset_level observed %b expected 0000", btn_level);
        end
        checks++;
        if (btn_press !== 4'b0000) begin
            errors++; $display("FAIL reset_press observed %b expected 0000", btn_press);
        end
        checks++;
        if (btn_release !== 4'b0000) begin
            errors++; $display("FAIL reset_release observed %b expected 0000", btn_release);
        end
        n = cyc;
        rst_n = 1'b1;
        for (int c = 0; c < N_CH; c++) push_ev(n + 6, c, 1'b1);
        for (int c = 0; c < N_CH; c++) push_ev(n + 12, c, 1'b0);
        wait_until(n + 5);
        checks++;
        if (btn_level !== 4'b0000) begin
            errors++; $display("FAIL reset_early_level observed %b expected 0000", btn_level);
        end
        wait_until(n + 6);
        checks++;
        if (btn_level !== 4'b1111) begin
            errors++; $display("FAIL reset_held_level observed %b expected 1111", btn_level);
        end
        btn_in = 4'b1111;
        wait_until(n + 14);
        checks++;
        if (btn_level !== 4'b0000) begin
            errors++; $display("FAIL reset_release_level observed %b expected 0000", btn_level);
        end
        wait_drain(10);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL reset_drain observed %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_clean_press;
        int n;
        rep_en = 4'b0000;
        n = cyc;
        btn_in[0] = 1'b0;
        push_ev(n + 6, 0, 1'b1);
        push_ev(n + 16, 0, 1'b0);
        wait_until(n + 5);
        checks++;
        if (btn_level[0] !== 1'b0) begin
            errors++; $display("FAIL clean_pre_level observed %b expected 0", btn_level[0]);
        end
        wait_until(n + 6);
        checks++;
        if (btn_level[0] !== 1'b1) begin
            errors++; $display("FAIL clean_level observed %b expected 1", btn_level[0]);
        end
        wait_until(n + 10);
        btn_in[0] = 1'b1;
        wait_until(n + 16);
        checks++;
        if (btn_level[0] !== 1'b0) begin
            errors++; $display("FAIL clean_rel_level observed %b expected 0", btn_level[0]);
        end
        wait_until(n + 24);
        wait_drain(10);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL clean_drain observed %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_glitch;
        int n;
        int g;
        n = cyc;
        btn_in[1] = 1'b0;
        wait_until(n + 3);
        btn_in[1] = 1'b1;
        wait_until(n + 10);
        checks++;
        if (btn_level[1] !== 1'b0) begin
            errors++; $display("FAIL glitch_level observed %b expected 0", btn_level[1]);
        end
        // Glitch, one high sample, then exactly four low samples.
        g = cyc;
        push_ev(g + 10, 1, 1'b1);
        push_ev(g + 14, 1, 1'b0);
        btn_in[1] = 1'b0;
        wait_until(g + 3);
        btn_in[1] = 1'b1;
        wait_until(g + 4);
        btn_in[1] = 1'b0;
        wait_until(g + 8);
        btn_in[1] = 1'b1;
        wait_until(g + 9);
        checks++;
        if (btn_level[1] !== 1'b0) begin
            errors++; $display("FAIL glitch_restart_level observed %b expected 0", btn_level[1]);
        end
        wait_until(g + 10);
        checks++;
        if (btn_level[1] !== 1'b1) begin
            errors++; $display("FAIL glitch_accept_level observed %b expected 1", btn_level[1]);
        end
        wait_until(g + 22);
        wait_drain(10);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL glitch_drain observed %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_auto_repeat;
        int p;
        rep_en = 4'b0100;
        p = cyc + 6;
        btn_in[2] = 1'b0;
        push_ev(p, 2, 1'b1);
        push_ev(p + 10, 2, 1'b1);
        push_ev(p + 13, 2, 1'b1);
        push_ev(p + 16, 2, 1'b1);
        push_ev(p + 18, 2, 1'b0);
        wait_until(p + 11);
        checks++;
        if (btn_level[2] !== 1'b1) begin
            errors++; $display("FAIL repeat_level observed %b expected 1", btn_level[2]);
        end
        wait_until(p + 12);
        btn_in[2] = 1'b1;
        wait_until(p + 30);
        wait_drain(10);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL repeat_drain observed %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_collision;
        int p;
        p = cyc + 6;
        btn_in[2] = 1'b0;
        push_ev(p, 2, 1'b1);
        push_ev(p + 10, 2, 1'b1);
        push_ev(p + 13, 2, 1'b0);
        wait_until(p + 7);
        btn_in[2] = 1'b1;
        wait_until(p + 13);
        checks++;
        if ({btn_press[2], btn_release[2]} !== 2'b01) begin
            errors++;
            $display("FAIL collision observed press,release=%b expected 01",
                     {btn_press[2], btn_release[2]});
        end
        wait_until(p + 25);
        wait_drain(10);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL collision_drain observed %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_rep_enable;
        int n;
        rep_en = 4'b0000;
        n = cyc;
        btn_in[1] = 1'b0;
        push_ev(n + 6, 1, 1'b1);
        push_ev(n + 19, 1, 1'b1);
        push_ev(n + 22, 1, 1'b1);
        push_ev(n + 32, 1, 1'b0);
        wait_until(n + 8);
        rep_en[1] = 1'b1;
        wait_until(n + 23);
        rep_en[1] = 1'b0;
        wait_until(n + 26);
        btn_in[1] = 1'b1;
        wait_until(n + 40);
        wait_drain(10);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL rep_enable_drain observed %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_mid_reset;
        int n;
        int r;
        rep_en = 4'b1000;
        n = cyc;
        btn_in[3] = 1'b0;
        push_ev(n + 6, 3, 1'b1);
        wait_until(n + 9);
        btn_in[0] = 1'b0;
        wait_until(n + 12);
        checks++;
        if (btn_level !== 4'b1000) begin
            errors++; $display("FAIL midreset_pre_level observed %b expected 1000", btn_level);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (btn_level !== 4'b0000) begin
            errors++; $display("FAIL midreset_level observed %b expected 0000", btn_level);
        end
        checks++;
        if ({btn_press, btn_release} !== 8'h00) begin
            errors++;
            $display("FAIL midreset_pulses observed %b expected 00000000", {btn_press, btn_release});
        end
        repeat (3) @(negedge clk50);
        r = cyc;
        rst_n = 1'b1;
        push_ev(r + 6, 0, 1'b1);
        push_ev(r + 6, 3, 1'b1);
        push_ev(r + 16, 3, 1'b1);
        push_ev(r + 19, 3, 1'b1);
        push_ev(r + 22, 3, 1'b1);
        push_ev(r + 23, 0, 1'b0);
        push_ev(r + 23, 3, 1'b0);
        wait_until(r + 5);
        checks++;
        if (btn_level !== 4'b0000) begin
            errors++; $display("FAIL midreset_early_level observed %b expected 0000", btn_level);
        end
        wait_until(r + 6);
        checks++;
        if (btn_level !== 4'b1001) begin
            errors++; $display("FAIL midreset_fresh_level observed %b expected 1001", btn_level);
        end
        wait_until(r + 17);
        btn_in = 4'b1111;
        wait_until(r + 30);
        wait_drain(10);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL midreset_drain observed %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_auto_repeat();
        test_collision();
        test_rep_enable();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
